// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared types and constants for the PWM output stage.
//   PWM_CNT_W     : width of the PWM timebase counter and duty value
//   PWM_OUT_W     : number of driven output pins
//   PWM_DUTY_FULL : duty code that forces a constant-high PWM level
//   pwm_cnt_t     : timebase counter / duty type
//   pwm_level_f   : PWM level for a given counter value and duty
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam int PWM_OUT_W = 16;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  localparam pwm_cnt_t PWM_DUTY_FULL = 8'hFF;

  // Full-scale duty is a special case so that 0xFF gives 100 % high with no
  // low slot at count 255; any other duty gives 'duty' high ticks per period.
  function automatic logic pwm_level_f(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == PWM_DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase
// Prescaler plus free-running 8-bit PWM counter shared by all pins.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   wrap         : (PWM_SYNC_UPDATE_EN builds only) last tick of a period,
//                  i.e. the clk in which pwm_cnt goes 255 -> 0
//   pwm_cnt      : current PWM count
//   period_start : registered one-clk pulse in the clk after the counters
//                  both hold zero
// Parameter PRESCALE: clk cycles per PWM count tick (>= 1).
// Optional macro PWM_SYNC_UPDATE_EN adds the wrap output.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic     clk,
  input  logic     rst_n,
`ifdef PWM_SYNC_UPDATE_EN
  output logic     wrap,
`endif
  output pwm_cnt_t pwm_cnt,
  output logic     period_start
);

  // A width of at least one bit keeps PRESCALE=1 legal; the counter then
  // sits at zero and every clk is a tick.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescale_cnt_reg;
  logic [PS_W-1:0] prescale_cnt_next;
  pwm_cnt_t        pwm_cnt_reg;
  pwm_cnt_t        pwm_cnt_next;
  logic            period_start_reg;
  logic            tick;

  assign tick = (prescale_cnt_reg == PS_MAX);

  always_comb begin
    prescale_cnt_next = prescale_cnt_reg + 1'b1;
    pwm_cnt_next      = pwm_cnt_reg;
    if (tick) begin
      prescale_cnt_next = '0;
      pwm_cnt_next      = pwm_cnt_reg + 1'b1;  // natural 255 -> 0 wrap
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_cnt_reg <= '0;
      pwm_cnt_reg      <= '0;
      period_start_reg <= 1'b0;
    end else begin
      prescale_cnt_reg <= prescale_cnt_next;
      pwm_cnt_reg      <= pwm_cnt_next;
      // Registered alongside the pin outputs so the pulse lines up with the
      // first output value of the new period.
      period_start_reg <= (pwm_cnt_reg == '0) && (prescale_cnt_reg == '0);
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  assign wrap = tick && (pwm_cnt_reg == PWM_DUTY_FULL);
`endif

  assign pwm_cnt      = pwm_cnt_reg;
  assign period_start = period_start_reg;

endmodule

// File: rtl/pwm_output_stage.sv
// pwm_output_stage
// Drives 16 pins from the register-file enables: each pin is static low,
// static high, or the shared PWM waveform. All outputs are registered.
// Ports:
//   clk             : system clock
//   rst_n           : asynchronous active-low reset
//   en_reg_out_7_0  : output enable, pins 7..0
//   en_reg_out_15_8 : output enable, pins 15..8
//   en_reg_pwm_7_0  : PWM mode select, pins 7..0
//   en_reg_pwm_15_8 : PWM mode select, pins 15..8
//   pwm_duty_cycle  : high ticks per 256-tick period, 0xFF = 100 %
//   out             : pin drive, bit i = pin i
//   period_start    : one-clk pulse at the start of each PWM period
// Parameter PRESCALE: clk cycles per PWM tick (>= 1).
// Optional macro PWM_SYNC_UPDATE_EN: duty is captured into a shadow register
// at each period wrap so mid-period writes cannot produce runt pulses.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [PWM_OUT_W-1:0] out,
  output logic                 period_start
);

  logic [PWM_OUT_W-1:0] en_out;
  logic [PWM_OUT_W-1:0] en_pwm;
  logic [PWM_OUT_W-1:0] out_next;
  logic [PWM_OUT_W-1:0] out_reg;
  pwm_cnt_t             pwm_cnt;
  pwm_cnt_t             duty_eff;
  logic                 pwm_level;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SYNC_UPDATE_EN
  logic     wrap;
  pwm_cnt_t duty_shadow_reg;

  pwm_timebase #(
    .PRESCALE     (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrap         (wrap),
    .pwm_cnt      (pwm_cnt),
    .period_start (period_start)
  );

  // Loaded on the last tick of a period so the new duty applies from count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_reg <= '0;
    end else if (wrap) begin
      duty_shadow_reg <= pwm_duty_cycle;
    end
  end

  assign duty_eff = duty_shadow_reg;
`else
  pwm_timebase #(
    .PRESCALE     (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_cnt      (pwm_cnt),
    .period_start (period_start)
  );

  assign duty_eff = pwm_duty_cycle;
`endif

  assign pwm_level = pwm_level_f(pwm_cnt, duty_eff);

  for (genvar gi = 0; gi < PWM_OUT_W; gi++) begin : g_pin
    assign out_next[gi] = en_out[gi] & (en_pwm[gi] ? pwm_level : 1'b1);
  end

  // Registering every pin keeps the pin drive free of decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else begin
      out_reg <= out_next;
    end
  end

  assign out = out_reg;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with PRESCALE=1 (period = 256 clk).
// 'cyc' counts rising edges since the last reset release; after edge n the
// DUT counter holds n mod 256 and the outputs reflect count (n-1) mod 256.
module tb_pwm_output_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

`ifdef PWM_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  pwm_output_stage #(
    .PRESCALE        (1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  // Advance at least one clk, stopping where the counter has just wrapped to 0.
  task automatic to_boundary();
    step();
    while (cyc % 256 != 0) step();
  endtask

  task automatic test_reset();
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000) begin
      failures++; $display("FAIL reset_out: got %h expected 0000", out);
    end
    checks++;
    if (period_start !== 1'b0) begin
      failures++; $display("FAIL reset_ps: got %b expected 0", period_start);
    end
    step(); step();
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      failures++; $display("FAIL reset_hold: got out=%h ps=%b expected 0000/0", out, period_start);
    end
    rst_n = 1'b1;
    cyc = 0;
    step();
    checks++;
    if (period_start !== 1'b1) begin
      failures++; $display("FAIL first_ps: got %b expected 1 at clk 1", period_start);
    end
    checks++;
    if (out !== (SYNC ? 16'h0000 : 16'hFFFF)) begin
      failures++; $display("FAIL first_out: got %h expected %h", out, SYNC ? 16'h0000 : 16'hFFFF);
    end
    step();
    checks++;
    if (period_start !== 1'b0) begin
      failures++; $display("FAIL ps_width: got %b expected 0 at clk 2", period_start);
    end
    while (cyc < 256) step();
    checks++;
    if (period_start !== 1'b0) begin
      failures++; $display("FAIL ps_early: got %b expected 0 at clk 256", period_start);
    end
    step();
    checks++;
    if (period_start !== 1'b1) begin
      failures++; $display("FAIL ps_period: got %b expected 1 at clk 257", period_start);
    end
    $display("reset: done, period_start seen at clk 1 and 257");
  endtask

  task automatic test_static();
    set_en(16'hFFFF, 16'h0000);
    pwm_duty_cycle = 8'h80;
    step();
    checks++;
    if (out !== 16'hFFFF) begin
      failures++; $display("FAIL static_all: got %h expected FFFF", out);
    end
    set_en(16'h00FF, 16'h0000);
    #1;
    checks++;
    if (out !== 16'hFFFF) begin
      failures++; $display("FAIL static_latency: got %h expected FFFF before edge", out);
    end
    step();
    checks++;
    if (out !== 16'h00FF) begin
      failures++; $display("FAIL static_low: got %h expected 00FF", out);
    end
    set_en(16'hA5A5, 16'h0000);
    step();
    checks++;
    if (out !== 16'hA5A5) begin
      failures++; $display("FAIL static_pattern: got %h expected A5A5", out);
    end
    $display("static: enables FFFF/00FF/A5A5 checked");
  endtask

  task automatic test_pwm_wave();
    int highs = 0;
    logic [15:0] exp;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h80;
    to_boundary();
    for (int j = 1; j <= 256; j++) begin
      step();
      exp = (j - 1 < 128) ? 16'hFFFF : 16'h0000;
      if (out == 16'hFFFF) highs++;
      checks++;
      if (out !== exp) begin
        failures++; $display("FAIL wave_out j=%0d: got %h expected %h", j, out, exp);
      end
      checks++;
      if (period_start !== (j == 1)) begin
        failures++; $display("FAIL wave_ps j=%0d: got %b expected %b", j, period_start, j == 1);
      end
    end
    checks++;
    if (highs != 128) begin
      failures++; $display("FAIL wave_highs: got %0d expected 128", highs);
    end
    $display("pwm_wave: duty 80 high clk count %0d", highs);
  endtask

  task automatic test_duty_extremes();
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h00;
    to_boundary();
    for (int j = 1; j <= 260; j++) begin
      step();
      checks++;
      if (out !== 16'h0000) begin
        failures++; $display("FAIL duty00 j=%0d: got %h expected 0000", j, out);
      end
    end
    set_en(16'h00FF, 16'h00F0);
    step();
    checks++;
    if (out !== 16'h000F) begin
      failures++; $display("FAIL mixed: got %h expected 000F", out);
    end
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    to_boundary();
    for (int j = 1; j <= 300; j++) begin
      step();
      checks++;
      if (out !== 16'hFFFF) begin
        failures++; $display("FAIL dutyFF j=%0d: got %h expected FFFF", j, out);
      end
    end
    $display("duty_extremes: 00, FF and mixed 000F checked");
  endtask

  task automatic test_duty_update();
    int highs0 = 0;
    int highs1 = 0;
    int c;
    int d;
    logic [15:0] exp;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h40;
    to_boundary();
    to_boundary();
    for (int j = 1; j <= 512; j++) begin
      step();
      c = (j - 1) % 256;
      if (SYNC) d = (j - 1 < 256) ? 8'h40 : 8'hC0;
      else      d = (j - 1 < 100) ? 8'h40 : 8'hC0;
      exp = (c < d) ? 16'hFFFF : 16'h0000;
      if (out == 16'hFFFF) begin
        if (j <= 256) highs0++;
        else          highs1++;
      end
      checks++;
      if (out !== exp) begin
        failures++; $display("FAIL upd_out j=%0d: got %h expected %h", j, out, exp);
      end
      if (j == 100) pwm_duty_cycle = 8'hC0;  // counter holds 100 here
    end
    checks++;
    if (highs0 != (SYNC ? 64 : 156)) begin
      failures++; $display("FAIL upd_highs0: got %0d expected %0d", highs0, SYNC ? 64 : 156);
    end
    checks++;
    if (highs1 != 192) begin
      failures++; $display("FAIL upd_highs1: got %0d expected 192", highs1);
    end
    $display("duty_update: period highs %0d then %0d", highs0, highs1);
  endtask

  task automatic test_reset_mid();
    set_en(16'hFFFF, 16'h0000);
    step();
    while (cyc % 256 != 50) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      failures++; $display("FAIL async_reset: got out=%h ps=%b expected 0000/0", out, period_start);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000) begin
      failures++; $display("FAIL mid_reset_hold: got %h expected 0000", out);
    end
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    rst_n = 1'b1;
    cyc = 0;
    step();
    checks++;
    if (period_start !== 1'b1) begin
      failures++; $display("FAIL restart_ps: got %b expected 1 at clk 1", period_start);
    end
    checks++;
    if (out !== (SYNC ? 16'h0000 : 16'hFFFF)) begin
      failures++; $display("FAIL restart_out: got %h expected %h", out, SYNC ? 16'h0000 : 16'hFFFF);
    end
    while (cyc < 100) step();
    checks++;
    if (out !== (SYNC ? 16'h0000 : 16'hFFFF)) begin
      failures++; $display("FAIL shadow_zero: got %h expected %h", out, SYNC ? 16'h0000 : 16'hFFFF);
    end
    while (cyc < 257) step();
    checks++;
    if (period_start !== 1'b1) begin
      failures++; $display("FAIL restart_period: got %b expected 1 at clk 257", period_start);
    end
    checks++;
    if (out !== 16'hFFFF) begin
      failures++; $display("FAIL restart_full: got %h expected FFFF", out);
    end
    $display("reset_mid: async clear and restart checked");
  endtask

  initial begin
    rst_n = 1'b0;
    set_en(16'h0000, 16'h0000);
    pwm_duty_cycle = 8'h00;
    test_reset();
    test_static();
    test_pwm_wave();
    test_duty_extremes();
    test_duty_update();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
